// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg: shared types and constants for the host-link command scheduler.
package tx_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;
  localparam int IDX_W = 3;
  localparam int DEFAULT_GAP_CYCLES = 100000;
  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx, input int n);
    return (int'(idx) + 1 >= n) ? '0 : idx + 1'b1;
  endfunction
endpackage

// File: rtl/tx_cmd_scheduler_if.sv
// tx_cmd_scheduler_if: request/ack bundle from the sources plus the UART transmit handshake.
interface tx_cmd_scheduler_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_valid;
  logic                      tx_ready;
  logic                      busy;
  logic [tx_sched_pkg::IDX_W-1:0] grant_idx;
  modport master (input req, req_data, tx_ready, output ack, tx_data, tx_valid, busy, grant_idx);
  modport slave (output req, req_data, tx_ready, input ack, tx_data, tx_valid, busy, grant_idx);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or after ptr.
module rr_arbiter
  import tx_sched_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] j;
  always_comb begin
    grant = '0;
    idx = '0;
    valid = 1'b0;
    j = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = IW'((int'(ptr) + k) % NUM_REQ);
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx = IDX_W'(j);
        grant[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tx_cmd_scheduler.sv
// tx_cmd_scheduler: round-robin sharing of the UART transmit path with an inter-frame gap.
module tx_cmd_scheduler
  import tx_sched_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input logic clk,
  input logic rst_n,
  tx_cmd_scheduler_if.master bus
);
  localparam int CW = $clog2(GAP_CYCLES + 1);
  state_t              state_q, state_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d, sel_data;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d, ptr_q, ptr_d, arb_idx;
  logic [NUM_REQ-1:0]  ack_q, ack_d, gnt;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                arb_vld;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (bus.req),
    .ptr   (ptr_q),
    .grant (gnt),
    .idx   (arb_idx),
    .valid (arb_vld)
  );
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      sel_data = sel_data | (bus.req_data[i*DATA_W +: DATA_W] & {DATA_W{gnt[i]}});
  end
  // the frame is captured at grant so later source changes cannot disturb it
  always_comb begin
    state_d = state_q;
    tx_data_d = tx_data_q;
    grant_idx_d = grant_idx_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ack_d = '0;
    case (state_q)
      IDLE: if (arb_vld) begin
        state_d = SEND;
        tx_data_d = sel_data;
        grant_idx_d = arb_idx;
      end
      SEND: if (bus.tx_ready) begin
        state_d = GAP;
        ack_d = NUM_REQ'(1) << grant_idx_q;
        ptr_d = next_ptr(grant_idx_q, NUM_REQ);
        cnt_d = CW'(GAP_CYCLES - 1);
      end
      GAP: begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tx_data_q <= '0;
      grant_idx_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      ack_q <= '0;
    end else begin
      state_q <= state_d;
      tx_data_q <= tx_data_d;
      grant_idx_q <= grant_idx_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ack_q <= ack_d;
    end
  end
  assign bus.ack = ack_q;
  assign bus.tx_data = tx_data_q;
  assign bus.tx_valid = state_q == SEND;
  assign bus.busy = state_q != IDLE;
  assign bus.grant_idx = grant_idx_q;
endmodule
